// File: rtl/dac_pkg.sv
// Shared defaults and helpers for the DAC feeder datapath.
package dac_pkg;

    localparam int DAC_RES_DEFAULT       = 7;
    localparam int DAC_HOLD_LOG2_DEFAULT = 8;

    typedef logic [DAC_RES_DEFAULT:0] dac_code_t;

    function automatic int dac_midscale(input int res);
        return 1 << res;
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous FIFO with an occupancy counter; reads are combinational from the head entry.
module dac_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Paces buffered samples onto the DAC input, one per 2**HOLD_LOG2 clocks, flagging underruns.
// Optional underrun counter output is enabled by defining DAC_FEEDER_UNDERRUN_CNT_EN.
module dac_sample_feeder
    import dac_pkg::*;
#(
    parameter int RES       = DAC_RES_DEFAULT,
    parameter int DEPTH     = 16,
    parameter int HOLD_LOG2 = DAC_HOLD_LOG2_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [RES:0]               s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [RES:0]               dac_code,
    output logic                       sample_tick,
    output logic                       underrun,
    input  logic                       clr_underrun,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                underrun_cnt
`endif
);

    localparam int           MID_INT = dac_midscale(RES);
    localparam logic [RES:0] MID     = MID_INT[RES:0];

    logic [HOLD_LOG2-1:0] pcnt;
    logic [RES:0]         head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 tc;
    logic                 pop;
    logic                 underrun_evt;

    assign s_ready      = !full;
    assign push         = s_valid && s_ready;
    assign tc           = enable && (pcnt == '1);
    assign pop          = tc && !empty;
    assign underrun_evt = tc && empty;

    dac_sample_fifo #(
        .WIDTH (RES+1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (s_data),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + HOLD_LOG2'(1);
        end
    end

    // Reset to midscale so the analog output does not step when the DAC starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            dac_code    <= MID;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= pop;
            if (pop) begin
                dac_code <= head;
            end
            if (underrun_evt) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    // A clear coinciding with a new underrun restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (underrun_evt) begin
            if (clr_underrun) begin
                underrun_cnt <= 16'd1;
            end else if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end else if (clr_underrun) begin
            underrun_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_dac_sample_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] dac_code;
    logic       sample_tick;
    logic       underrun;
    logic       clr_underrun = 1'b0;
    logic [4:0] level;
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    dac_sample_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dac_code     (dac_code),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .level        (level)
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a sample queue, a period phase and the visible output values.
    logic [7:0] modelQ[$];
    int         modelPhase = 0;
    logic [7:0] modelCode = 8'h80;
    logic       modelTick = 1'b0;
    logic       modelUnder = 1'b0;
    int         modelCnt = 0;

    always @(posedge clk) begin
        bit tcNow, pushNow, underNow;
        if (reset) begin
            modelQ.delete();
            modelPhase = 0;
            modelCode  = 8'h80;
            modelTick  = 1'b0;
            modelUnder = 1'b0;
            modelCnt   = 0;
        end else begin
            pushNow   = s_valid && (modelQ.size() < 16);
            tcNow     = enable && (modelPhase == 255);
            underNow  = tcNow && (modelQ.size() == 0);
            modelTick = 1'b0;
            if (tcNow && !underNow) begin
                modelCode = modelQ.pop_front();
                modelTick = 1'b1;
            end
            if (underNow) begin
                modelUnder = 1'b1;
                modelCnt   = clr_underrun ? 1 : ((modelCnt < 65535) ? modelCnt + 1 : 65535);
            end else if (clr_underrun) begin
                modelUnder = 1'b0;
                modelCnt   = 0;
            end
            if (pushNow) modelQ.push_back(s_data);
            modelPhase = enable ? (modelPhase + 1) % 256 : 0;
        end
        #1;
        checkOutput("model_dac_code", dac_code, modelCode);
        checkOutput("model_sample_tick", sample_tick, modelTick);
        checkOutput("model_underrun", underrun, modelUnder);
        checkOutput("model_level", level, modelQ.size());
        checkOutput("model_s_ready", s_ready, modelQ.size() < 16);
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        checkOutput("model_underrun_cnt", underrun_cnt, modelCnt);
`endif
    end

    task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                 input logic en, input logic clr, input int cycles);
        s_valid      = valid;
        s_data       = data;
        enable       = en;
        clr_underrun = clr;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyReset();
        s_valid = 1'b0; enable = 1'b0; clr_underrun = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int den;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_dac_code", dac_code, 8'h80);
        checkOutput("reset_level", level, 0);
        checkOutput("reset_s_ready", s_ready, 1);
        checkOutput("reset_underrun", underrun, 0);
        checkOutput("reset_tick", sample_tick, 0);

        // Idle with pacing on: underrun appears after the first terminal count.
        applyStimulus(0, 8'h00, 1, 0, 255);
        checkOutput("idle_underrun_pre_tc", underrun, 0);
        applyStimulus(0, 8'h00, 1, 0, 1);
        checkOutput("idle_underrun_post_tc", underrun, 1);
        checkOutput("idle_dac_code", dac_code, 8'h80);

        // Three queued samples step out one per period.
        applyReset();
        applyStimulus(1, 8'h01, 0, 0, 1);
        applyStimulus(1, 8'h02, 0, 0, 1);
        applyStimulus(1, 8'h03, 0, 0, 1);
        applyStimulus(0, 8'h00, 1, 0, 256);
        checkOutput("seq_first_code", dac_code, 8'h01);
        checkOutput("seq_first_tick", sample_tick, 1);
        applyStimulus(0, 8'h00, 1, 0, 255);
        checkOutput("seq_hold_code", dac_code, 8'h01);
        checkOutput("seq_hold_tick", sample_tick, 0);
        applyStimulus(0, 8'h00, 1, 0, 1);
        checkOutput("seq_second_code", dac_code, 8'h02);
        applyStimulus(0, 8'h00, 1, 0, 256);
        checkOutput("seq_third_code", dac_code, 8'h03);
        applyStimulus(0, 8'h00, 1, 0, 256);
        checkOutput("seq_drain_underrun", underrun, 1);
        checkOutput("seq_drain_code", dac_code, 8'h03);

        // Fill to capacity with pacing off, then refuse one more.
        applyReset();
        for (int i = 0; i < 16; i++) applyStimulus(1, 8'(8'h10 + i), 0, 0, 1);
        checkOutput("full_level", level, 16);
        checkOutput("full_s_ready", s_ready, 0);
        applyStimulus(1, 8'hAA, 0, 0, 1);
        checkOutput("full_reject_level", level, 16);
        checkOutput("full_dac_code", dac_code, 8'h80);

        // Enable from full: first pop one period later, refill on the freed slot.
        applyStimulus(0, 8'h00, 1, 0, 256);
        checkOutput("full_pop_level", level, 15);
        checkOutput("full_pop_s_ready", s_ready, 1);
        checkOutput("full_pop_code", dac_code, 8'h10);
        applyStimulus(1, 8'hBB, 1, 0, 1);
        checkOutput("full_refill_level", level, 16);

        // Push exactly on the terminal-count cycle into an empty FIFO.
        applyReset();
        applyStimulus(0, 8'h00, 1, 0, 255);
        checkOutput("tcpush_pre_underrun", underrun, 0);
        applyStimulus(1, 8'h5A, 1, 0, 1);
        checkOutput("tcpush_underrun", underrun, 1);
        checkOutput("tcpush_level", level, 1);
        checkOutput("tcpush_code_hold", dac_code, 8'h80);
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        checkOutput("tcpush_cnt", underrun_cnt, 1);
`endif
        applyStimulus(0, 8'h00, 1, 0, 255);
        checkOutput("tcpush_wait_code", dac_code, 8'h80);
        applyStimulus(0, 8'h00, 1, 0, 1);
        checkOutput("tcpush_load_code", dac_code, 8'h5A);
        checkOutput("tcpush_load_tick", sample_tick, 1);

        // Reset mid-stream flushes everything.
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h60 + i), 0, 0, 1);
        checkOutput("midreset_level_pre", level, 5);
        applyReset();
        checkOutput("midreset_level", level, 0);
        checkOutput("midreset_code", dac_code, 8'h80);
        checkOutput("midreset_underrun", underrun, 0);
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        checkOutput("midreset_cnt", underrun_cnt, 0);
`endif

        // Random traffic with varying push density, occasional enable drops and clears.
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(0, 2))
                0:       den = 40;
                1:       den = 250;
                default: den = 700;
            endcase
            for (int c = 0; c < 300; c++) begin
                applyStimulus($urandom_range(0, den - 1) < 3, 8'($urandom),
                              $urandom_range(0, 499) != 0 || (c % 100) > 3,
                              $urandom_range(0, 299) == 0, 1);
            end
        end
        applyStimulus(0, 8'h00, 0, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Upstream pacing stage for the 8-bit `dac` block. It accepts samples from a producer over a valid/ready handshake and buffers them in a small synchronous FIFO. It presents exactly one sample to the DAC's `dac_in` per DAC conversion period, with a one-cycle load strobe. Underruns are detected and flagged, and the DAC input holds its last value through them.

## Interface
- `RES`, default 7: DAC resolution minus one; sample width is RES+1.
- `DEPTH`, default 16: FIFO entries; power of two, ≥2.
- `HOLD_LOG2`, default 8: log2 of clocks per sample. The period is 2**HOLD_LOG2 = 256 clocks, which matches one full DAC cycle at RES=7.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  pacing enable; low freezes output and holds counter at 0.
- `s_data`  in  RES+1  producer sample.
- `s_valid`  in  1  producer sample valid.
- `s_ready`  out  1  FIFO can accept; equals (level < DEPTH).
- `dac_code`  out  RES+1  registered sample to DAC `dac_in`.
- `sample_tick`  out  1  one-cycle pulse, high in the first cycle a new `dac_code` is visible.
- `underrun`  out  1  sticky; set when a period boundary finds the FIFO empty.
- `clr_underrun`  in  1  synchronous clear of `underrun`.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Push occurs when s_valid && s_ready; s_data is written at the write pointer and level increments.
- Pacing counter `pcnt` (HOLD_LOG2 bits):
  - Increments each cycle while enable=1 and wraps from 2**HOLD_LOG2-1 to 0.
  - When enable=0, `pcnt` is forced to 0.
- Terminal count (TC) is pcnt==2**HOLD_LOG2-1 with enable=1. On TC:
  - If level>0: pop the head into `dac_code` and pulse `sample_tick` next cycle.
  - If level==0: `dac_code` unchanged, no tick, `underrun` set.
- Push and pop on the same cycle: both take effect and level is unchanged.
- At full, `s_ready`=0 even if a pop occurs that cycle. There is no same-cycle refill.
- At empty, a push coinciding with TC does not bypass: the pop sees level=0, so underrun is flagged, and the pushed sample waits for the next TC.
- Pointers wrap modulo DEPTH.
- If `clr_underrun` and a new underrun occur in the same cycle, set wins.
- Reset values:
  - `dac_code` = 1<<RES (midscale, 0x80), to avoid a step on the analog output.
  - `sample_tick`=0, `underrun`=0, `level`=0.
  - `s_ready`=1 from the first cycle after reset.
  - `pcnt`=0 and pointers=0.
- Reset mid-operation flushes the FIFO. Any in-flight sample is discarded.

## Timing
- Push visible in `level` one cycle after the handshake cycle.
- Latency, empty FIFO, enable high, push at cycle t: the sample appears on `dac_code` at the cycle after the first TC at or after t+1.
- `dac_code` changes only on the edge ending a TC cycle. It is stable for exactly 2**HOLD_LOG2 cycles between loads while no underrun occurs.
- After enable rises, the first TC is 2**HOLD_LOG2-1 cycles later, so the first load comes one full period after enabling.
- `s_ready` is derived combinationally from registered `level`. It has no combinational path from `s_valid`.

## Configuration
- `DAC_FEEDER_UNDERRUN_CNT_EN`:
  - Defined: adds output `underrun_cnt` (16 bits), which increments on every underrun TC, saturates at 0xFFFF, and is cleared by reset or `clr_underrun`.
  - Undefined: the port and counter are absent. Only the sticky `underrun` flag exists.

## Structure
- Package `dac_pkg`:
  - `DAC_RES_DEFAULT`=7 and `DAC_HOLD_LOG2_DEFAULT`=8.
  - Function `dac_midscale(res)` returning 1<<res.
  - Typedef `dac_code_t` for the default 8-bit width.
- Sub-module `dac_sample_fifo` contains the storage, pointers and level, with ports push/pop/wdata/rdata/level/full/empty. The feeder top holds the pacing counter, output register and flags.

## Test plan
- Reset then idle, enable=1, no pushes:
  - `dac_code`=0x80 throughout.
  - `underrun` rises after the edge ending the first TC (cycle 255 after enable).
  - `sample_tick` never pulses.
- Push 0x01,0x02,0x03 back-to-back, enable=1 → `dac_code` steps 0x01→0x02→0x03, each held exactly 256 clocks, with one `sample_tick` per step.
- Push 16 samples with enable=0 → `level`=16 and `s_ready`=0, a 17th valid is not accepted, and `dac_code` stays 0x80.
- With the FIFO full, raise enable → the first pop after 256 clocks, and `s_ready` rises the cycle after the pop. A push on that cycle is accepted and `level` returns to 16.
- Push at the exact TC cycle into an empty FIFO → `underrun` is set, and the sample loads at the next TC, 256 clocks later.
- Assert reset mid-stream with `level`=5 → next cycle `level`=0, `dac_code`=0x80 and `underrun`=0. With the macro defined, `underrun_cnt`=0.
